pulse_gen: RTL
==============

Name: pulse_gen

Overview:
- Programmable single-channel pulse train generator.
- Consumes the synchronised reset produced by the board reset stage, inverted to active-high `rst` at the top level, and the system clock.
- On a start request it outputs N pulses: programmable initial delay, high width and period.
- Feeds the board output pin driver.

Parameters:
CNT_W, 32, width of delay/width/period counters and config inputs
NP_W, 16, width of pulse-count config (0 = continuous)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_delay  in  CNT_W  cycles from start acceptance to first rising edge
cfg_width  in  CNT_W  high time in cycles
cfg_period  in  CNT_W  rising-edge-to-rising-edge time in cycles
cfg_npulse  in  NP_W  number of pulses; 0 = run until stop
start  in  1  level-sampled request; accepted only in IDLE
stop  in  1  abort request, any state
busy  out  1  high from acceptance cycle+1 until return to IDLE
done  out  1  one-cycle strobe on completion or abort
cfg_err  out  1  one-cycle strobe: start rejected due to bad config
pulse_out  out  1  registered pulse output

Behaviour:
- Reset (rst sampled high at posedge clk):
  - state=IDLE, all counters 0.
  - busy=0, done=0, cfg_err=0, pulse_out=0.
  - Reset mid-train: pulse_out drops on that edge; no done strobe.
- Config validity is checked at start in IDLE:
  - Valid requires 1 <= cfg_width < cfg_period.
  - Invalid: cfg_err=1 for one cycle, stay IDLE.
  - cfg_delay=0 is legal.
- Config is latched at acceptance. Input changes while busy are ignored.
- States: IDLE, DELAY, HIGH, LOW.
  - IDLE: start && !stop && valid -> DELAY if cfg_delay>0, else HIGH. busy=1 next cycle.
  - DELAY: counts cfg_delay cycles, then HIGH.
  - HIGH: pulse_out=1 for exactly width cycles, then LOW.
  - LOW: pulse_out=0 for exactly period-width cycles. Then:
    - pulses_sent < npulse, or npulse==0 -> HIGH.
    - otherwise -> IDLE with done=1 for that one cycle and busy=0.
- Timing (start sampled at edge k):
  - pulse_out rises at edge k+1+delay.
  - Subsequent rises every period cycles.
- Completion: done asserts on the edge where the last LOW phase ends.
- Stop:
  - Sampled high in DELAY/HIGH/LOW: next edge state=IDLE, pulse_out=0, busy=0, done=1 (one cycle).
  - In IDLE, stop has no effect.
  - start && stop in IDLE: stop wins; no acceptance, no cfg_err.
- start held high: a new train starts on the first IDLE cycle after done, i.e. one dead cycle between trains.
- start while busy: ignored, not queued.
- Pulse counter:
  - Increments on each HIGH entry.
  - In continuous mode the counter wraps silently and never terminates.
- Counter width rules:
  - All compares are unsigned CNT_W.
  - Phase counters load value-1 and count down to 0, so max width/period = 2^CNT_W-1.
- Outputs are registered. No combinational path from inputs to pulse_out.

Decomposition:
- Package pulse_gen_pkg holds:
  - state encoding constants (IDLE, DELAY, HIGH, LOW, 2 bits)
  - default CNT_W/NP_W
- One natural sub-module, pulse_timer: loadable down-counter with load, en and zero flag, width CNT_W.
  - Shared by DELAY, HIGH and LOW phases; reloaded on each state entry.

Test Plan:
- Basic train:
  - Stimulus: delay=3, width=2, period=5, npulse=3, start pulse at edge k.
  - Response: pulse_out high edges k+4..k+5, k+9..k+10, k+14..k+15. done at edge k+18. busy k+1..k+17.
- Zero delay + back-to-back:
  - Stimulus: delay=0, width=1, period=2, npulse=2, start held high.
  - Response: pulse_out rises k+1, k+3. done at k+4. Second train accepted k+5, pulse at k+6.
- Bad config:
  - Stimulus: width=5, period=5 (then width=0), start.
  - Response: cfg_err one cycle each, busy stays 0, pulse_out 0.
- Abort:
  - Stimulus: npulse=0, width=4, period=10; stop asserted mid-HIGH.
  - Response: pulse_out 0 and busy 0 next edge, done one cycle, no further pulses.
- Start+stop / start while busy:
  - Stimulus: simultaneous start&stop in IDLE, then start pulses during a running train.
  - Response: no acceptance; running train unchanged in count and timing.
- Reset mid-operation:
  - Stimulus: rst high for 1 cycle during LOW of pulse 2.
  - Response: all outputs 0 on that edge, no done. A fresh start afterwards reproduces the basic-train timing exactly.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared encodings and default widths for the pulse train generator.
package pulse_gen_pkg;

    localparam int DEF_CNT_W = 32;
    localparam int DEF_NP_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter shared by the DELAY, HIGH and LOW phases.
// A phase of N cycles is timed by loading N-1 on entry and leaving when zero is seen.
module pulse_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down while enabled and stop at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_gen.sv
// Programmable single-channel pulse train generator.
//
// state   | meaning
// IDLE    | waiting for an accepted start
// DELAY   | initial delay before the first pulse
// HIGH    | pulse high phase (width cycles)
// LOW     | pulse low phase (period - width cycles)
//
// pulse_out is the registered image of the HIGH phase, one cycle behind the
// state register, so the first rising edge lands delay+1 edges after acceptance.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NP_W  = DEF_NP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [NP_W-1:0]  cfg_npulse,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             pulse_out
);

    state_t           state;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] low_len_q;
    logic [NP_W-1:0]  npulse_q;
    logic [NP_W-1:0]  pulses_sent;

    logic             cfg_valid;
    logic             accept;
    logic             more_pulses;
    logic             tmr_load;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_zero;

    assign cfg_valid   = (cfg_width != '0) && (cfg_width < cfg_period);
    assign accept      = (state == ST_IDLE) && start && !stop && cfg_valid;
    assign more_pulses = (npulse_q == '0) || (pulses_sent < npulse_q);

    // Reload the phase timer on every state entry with that phase length minus one.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        tmr_en    = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    tmr_load  = 1'b1;
                    tmr_value = (cfg_delay != '0) ? (cfg_delay - CNT_W'(1))
                                                  : (cfg_width - CNT_W'(1));
                end
            end
            ST_DELAY: begin
                if (tmr_zero) begin
                    tmr_load  = 1'b1;
                    tmr_value = width_q - CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (tmr_zero) begin
                    tmr_load  = 1'b1;
                    tmr_value = low_len_q - CNT_W'(1);
                end
            end
            ST_LOW: begin
                if (tmr_zero && more_pulses) begin
                    tmr_load  = 1'b1;
                    tmr_value = width_q - CNT_W'(1);
                end
            end
            default: begin
                tmr_load  = 1'b0;
                tmr_value = '0;
            end
        endcase
    end

    pulse_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .en    (tmr_en),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    // Sequencing FSM with registered status strobes and pulse output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            pulse_out   <= 1'b0;
            width_q     <= '0;
            low_len_q   <= '0;
            npulse_q    <= '0;
            pulses_sent <= '0;
        end else begin
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            pulse_out <= (state == ST_HIGH);

            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        if (cfg_valid) begin
                            width_q   <= cfg_width;
                            low_len_q <= cfg_period - cfg_width;
                            npulse_q  <= cfg_npulse;
                            busy      <= 1'b1;
                            if (cfg_delay != '0) begin
                                state       <= ST_DELAY;
                                pulses_sent <= '0;
                            end else begin
                                state       <= ST_HIGH;
                                pulses_sent <= NP_W'(1);
                            end
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (tmr_zero) begin
                        state       <= ST_HIGH;
                        pulses_sent <= pulses_sent + NP_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (tmr_zero) begin
                        state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (tmr_zero) begin
                        if (more_pulses) begin
                            state       <= ST_HIGH;
                            pulses_sent <= pulses_sent + NP_W'(1);
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Abort overrides whatever the phase logic decided this cycle.
            if ((state != ST_IDLE) && stop) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                done      <= 1'b1;
                pulse_out <= 1'b0;
            end
        end
    end

endmodule
